aexm_bpcu_ras: RTL and testbench

- Next-generation branch/PC unit for the aexm core.
- Keeps the existing behaviour:
  - branch condition evaluation on the forwarded operand A;
  - delay-slot and skip tracking;
  - PC, link and fetch-address pipeline.
- New capabilities:
  - parametrised prefetch depth between the fetch address and the decoded PC;
  - parametrised return-address stack (RAS) that records branch-and-link sites and checks each return-from-subroutine target against it;
  - hit/miss counters and sticky overflow/underflow flags for the debug/profiling bus.

---
 rtl/aexm_bpcu_ras.sv | 182 ++++++++++++++++++
 tb/tb_aexm_bpcu_ras.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aexm_bpcu_ras.sv
// aexm_bpcu_ras: branch/PC unit with a configurable prefetch pipeline and a
// return-address stack that scores every return against the recorded link site.
module aexm_bpcu_ras #(
   parameter int IW  = 24,
   parameter int PFD = 2,
   parameter int RAW = 3,
   parameter int CW  = 16
) (
   input  logic          gclk,
   input  logic          grst,
   input  logic          x_en,
   input  logic [1:0]    rMXALT,
   input  logic [5:0]    rOPC,
   input  logic [4:0]    rRD,
   input  logic [4:0]    rRA,
   input  logic [31:0]   xRESULT,
   input  logic [31:0]   rRESULT,
   input  logic [31:0]   rDWBDI,
   input  logic [31:0]   rREGA,
   input  logic          ras_clr,
   output logic [IW-3:0] aexm_icache_precycle_addr,
   output logic [29:0]   rPC,
   output logic [29:0]   rPCLNK,
   output logic          rSKIP,
   output logic [29:0]   rRASTOP,
   output logic [RAW:0]  rRASCNT,
   output logic          rRASOVF,
   output logic          rRASUNF,
   output logic [CW-1:0] rHITCNT,
   output logic [CW-1:0] rMISCNT
);

   localparam int DEPTH = 1 << RAW;
   localparam logic [RAW:0] CNT_FULL = {1'b1, {RAW{1'b0}}};
   localparam logic [RAW:0] CNT_ONE  = {{RAW{1'b0}}, 1'b1};

   // decode and branch resolution
   logic          rtd, bcc, bru, lnk;
   logic [31:0]   rega;
   logic          zero, neg, cond;
   logic          bra, dly, skip_next;
   logic [29:0]   ipc_next;

   // prefetch pipeline and branch history
   logic [29:0]   pipe [PFD];
   logic [29:0]   ipc;
   logic          bra_q, dly_q;

   // return-address stack
   logic [29:0]   stack [DEPTH];
   logic [RAW-1:0] wp, top_ptr;
   logic          valid, push, pop, empty, full;
   logic [29:0]   predicted;
   logic          pred_hit;

   logic          unused_bits;

   // opcode decode, operand-A forwarding and condition evaluation
   always_comb begin
      rtd = (rOPC == 6'o55);
      bcc = (rOPC == 6'o47) || (rOPC == 6'o57);
      bru = (rOPC == 6'o46) || (rOPC == 6'o56);
      lnk = bru & rRA[2];

      case (rMXALT)
         2'd2:    rega = rDWBDI;
         2'd1:    rega = rRESULT;
         default: rega = rREGA;
      endcase

      zero = (rega == '0);
      neg  = rega[31];

      case (rRD[2:0])
         3'd0:    cond = zero;
         3'd1:    cond = ~zero;
         3'd2:    cond = neg;
         3'd3:    cond = neg | zero;
         3'd4:    cond = ~(neg | zero);
         3'd5:    cond = ~neg;
         default: cond = 1'b0;
      endcase

      bra       = rtd | bru | (bcc & cond);
      dly       = (bru & rRA[4]) | (bcc & rRD[4]) | rtd;
      skip_next = (bra & ~dly) | bra_q;
      ipc_next  = bra ? xRESULT[31:2] : pipe[0] + 30'd1;
   end

   assign ipc = pipe[PFD-1];
   assign aexm_icache_precycle_addr = ipc_next[IW-3:0];

   // prefetch pipeline, PC/link pipeline and skip tracking
   always_ff @(posedge gclk) begin
      if (grst) begin
         for (int unsigned k = 0; k < PFD; k++) begin
            pipe[k] <= '0;
         end
         rPC    <= '0;
         rPCLNK <= '0;
         bra_q  <= 1'b0;
         dly_q  <= 1'b0;
         rSKIP  <= 1'b0;
      end else if (x_en) begin
         pipe[0] <= ipc_next;
         for (int unsigned k = 1; k < PFD; k++) begin
            pipe[k] <= pipe[k-1];
         end
         rPC    <= ipc;
         rPCLNK <= rPC;
         bra_q  <= bra;
         dly_q  <= dly;
         rSKIP  <= skip_next;
      end
   end

   // RAS event qualification and return prediction
   always_comb begin
      valid     = ~rSKIP;
      push      = valid & lnk;
      pop       = valid & rtd;
      empty     = (rRASCNT == '0);
      full      = (rRASCNT == CNT_FULL);
      top_ptr   = wp - RAW'(1);
      predicted = stack[top_ptr] + 30'd2;
      pred_hit  = (xRESULT[31:2] == predicted);
      rRASTOP   = empty ? '0 : stack[top_ptr];
   end

   // stack storage; contents are unreachable while the count is zero, so no reset
   always_ff @(posedge gclk) begin
      if (!grst && x_en && push) begin
         stack[wp] <= rPC;
      end
   end

   // pointer, count, sticky flags and saturating hit/miss counters
   always_ff @(posedge gclk) begin
      if (grst) begin
         wp      <= '0;
         rRASCNT <= '0;
         rRASOVF <= 1'b0;
         rRASUNF <= 1'b0;
         rHITCNT <= '0;
         rMISCNT <= '0;
      end else if (x_en) begin
         // a full-stack push overwrites the oldest entry, which is exactly the slot at wp
         if (push) begin
            wp <= wp + RAW'(1);
            if (!full) begin
               rRASCNT <= rRASCNT + CNT_ONE;
            end
         end else if (pop && !empty) begin
            wp      <= top_ptr;
            rRASCNT <= rRASCNT - CNT_ONE;
         end

         if (ras_clr) begin
            rRASOVF <= 1'b0;
            rRASUNF <= 1'b0;
            rHITCNT <= '0;
            rMISCNT <= '0;
         end else begin
            if (push && full) begin
               rRASOVF <= 1'b1;
            end
            if (pop && empty) begin
               rRASUNF <= 1'b1;
            end
            if (pop && !empty && pred_hit && rHITCNT != '1) begin
               rHITCNT <= rHITCNT + CW'(1);
            end
            if (pop && (empty || !pred_hit) && rMISCNT != '1) begin
               rMISCNT <= rMISCNT + CW'(1);
            end
         end
      end
   end

   assign unused_bits = ^{rRA[1:0], rRA[3], rRD[3], xRESULT[1:0], ipc_next, dly_q};

endmodule

// File: tb/tb_aexm_bpcu_ras.sv
// Randomized bench for aexm_bpcu_ras: two configurations driven in parallel and
// compared against a queue-based reference model of fetch pipeline and return stack.
module tb_aexm_bpcu_ras;

   localparam int IW = 24;

   logic          gclk = 1'b0;
   logic          grst, x_en, ras_clr;
   logic [1:0]    rMXALT;
   logic [5:0]    rOPC;
   logic [4:0]    rRD, rRA;
   logic [31:0]   xRESULT, rRESULT, rDWBDI, rREGA;

   logic [IW-3:0] addr0, addr1;
   logic [29:0]   pc0, pc1, lnk0, lnk1, top0, top1;
   logic          skip0, skip1, ovf0, ovf1, unf0, unf1;
   logic [3:0]    cnt0;
   logic [1:0]    cnt1;
   logic [15:0]   hit0, mis0;
   logic [1:0]    hit1, mis1;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   always #5 gclk = ~gclk;

   aexm_bpcu_ras #(.IW(IW), .PFD(2), .RAW(3), .CW(16)) u_dut (
      .gclk(gclk), .grst(grst), .x_en(x_en), .rMXALT(rMXALT), .rOPC(rOPC),
      .rRD(rRD), .rRA(rRA), .xRESULT(xRESULT), .rRESULT(rRESULT), .rDWBDI(rDWBDI),
      .rREGA(rREGA), .ras_clr(ras_clr), .aexm_icache_precycle_addr(addr0),
      .rPC(pc0), .rPCLNK(lnk0), .rSKIP(skip0), .rRASTOP(top0), .rRASCNT(cnt0),
      .rRASOVF(ovf0), .rRASUNF(unf0), .rHITCNT(hit0), .rMISCNT(mis0)
   );

   aexm_bpcu_ras #(.IW(IW), .PFD(3), .RAW(1), .CW(2)) u_small (
      .gclk(gclk), .grst(grst), .x_en(x_en), .rMXALT(rMXALT), .rOPC(rOPC),
      .rRD(rRD), .rRA(rRA), .xRESULT(xRESULT), .rRESULT(rRESULT), .rDWBDI(rDWBDI),
      .rREGA(rREGA), .ras_clr(ras_clr), .aexm_icache_precycle_addr(addr1),
      .rPC(pc1), .rPCLNK(lnk1), .rSKIP(skip1), .rRASTOP(top1), .rRASCNT(cnt1),
      .rRASOVF(ovf1), .rRASUNF(unf1), .rHITCNT(hit1), .rMISCNT(mis1)
   );

   // reference model state, index 0 = u_dut, 1 = u_small
   int unsigned m_pfd   [2] = '{2, 3};
   int unsigned m_depth [2] = '{8, 2};
   int unsigned m_cmax  [2] = '{65535, 3};
   logic [29:0] m_pipe  [2][$];
   logic [29:0] m_stk   [2][$];
   logic [29:0] m_pc [2], m_lnk [2];
   bit          m_bra [2], m_skip [2], m_ovf [2], m_unf [2];
   int unsigned m_hit [2], m_mis [2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic void decode(output bit o_rtd, output bit o_lnk, output bit o_bra,
                                  output bit o_dly);
      bit bcc, bru, cnd, zero, neg;
      logic [31:0] a;
      o_rtd = (rOPC == 6'o55);
      bcc   = (rOPC == 6'o47) || (rOPC == 6'o57);
      bru   = (rOPC == 6'o46) || (rOPC == 6'o56);
      o_lnk = bru && rRA[2];
      a     = (rMXALT == 2'd2) ? rDWBDI : (rMXALT == 2'd1) ? rRESULT : rREGA;
      zero  = (a == 32'd0);
      neg   = a[31];
      case (rRD[2:0])
         3'd0:    cnd = zero;
         3'd1:    cnd = !zero;
         3'd2:    cnd = neg;
         3'd3:    cnd = neg || zero;
         3'd4:    cnd = !neg && !zero;
         3'd5:    cnd = !neg;
         default: cnd = 1'b0;
      endcase
      o_bra = o_rtd || bru || (bcc && cnd);
      o_dly = (bru && rRA[4]) || (bcc && rRD[4]) || o_rtd;
   endfunction

   function automatic logic [29:0] model_xipc(input int i);
      bit r, l, b, d;
      decode(r, l, b, d);
      return b ? xRESULT[31:2] : m_pipe[i][0] + 30'd1;
   endfunction

   function automatic logic [29:0] model_top(input int i);
      return (m_stk[i].size() > 0) ? m_stk[i][m_stk[i].size()-1] : 30'd0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pipe[i].delete();
         repeat (m_pfd[i]) m_pipe[i].push_back(30'd0);
         m_stk[i].delete();
         m_pc[i] = '0; m_lnk[i] = '0;
         m_bra[i] = 0; m_skip[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
         m_hit[i] = 0; m_mis[i] = 0;
      end
   endtask

   task automatic model_step();
      bit r, l, b, d, valid, ev_ovf, ev_unf, ev_hit, ev_mis;
      logic [29:0] xipc, pred;
      decode(r, l, b, d);
      for (int i = 0; i < 2; i++) begin
         xipc  = model_xipc(i);
         valid = !m_skip[i];
         ev_ovf = 0; ev_unf = 0; ev_hit = 0; ev_mis = 0;
         if (valid && l) begin
            if (m_stk[i].size() == m_depth[i]) begin
               void'(m_stk[i].pop_front());
               ev_ovf = 1;
            end
            m_stk[i].push_back(m_pc[i]);
         end
         if (valid && r) begin
            if (m_stk[i].size() > 0) begin
               pred = model_top(i) + 30'd2;
               if (xRESULT[31:2] == pred) ev_hit = 1; else ev_mis = 1;
               void'(m_stk[i].pop_back());
            end else begin
               ev_mis = 1;
               ev_unf = 1;
            end
         end
         if (ras_clr) begin
            m_ovf[i] = 0; m_unf[i] = 0; m_hit[i] = 0; m_mis[i] = 0;
         end else begin
            if (ev_ovf) m_ovf[i] = 1;
            if (ev_unf) m_unf[i] = 1;
            if (ev_hit && m_hit[i] < m_cmax[i]) m_hit[i]++;
            if (ev_mis && m_mis[i] < m_cmax[i]) m_mis[i]++;
         end
         m_lnk[i] = m_pc[i];
         m_pc[i]  = m_pipe[i][m_pfd[i]-1];
         m_pipe[i].push_front(xipc);
         void'(m_pipe[i].pop_back());
         m_skip[i] = (b && !d) || m_bra[i];
         m_bra[i]  = b;
      end
   endtask

   task automatic check_regs();
      chk("pc0", 64'(pc0), 64'(m_pc[0]));        chk("pc1", 64'(pc1), 64'(m_pc[1]));
      chk("lnk0", 64'(lnk0), 64'(m_lnk[0]));     chk("lnk1", 64'(lnk1), 64'(m_lnk[1]));
      chk("skip0", 64'(skip0), 64'(m_skip[0]));  chk("skip1", 64'(skip1), 64'(m_skip[1]));
      chk("top0", 64'(top0), 64'(model_top(0))); chk("top1", 64'(top1), 64'(model_top(1)));
      chk("cnt0", 64'(cnt0), 64'(m_stk[0].size())); chk("cnt1", 64'(cnt1), 64'(m_stk[1].size()));
      chk("ovf0", 64'(ovf0), 64'(m_ovf[0]));     chk("ovf1", 64'(ovf1), 64'(m_ovf[1]));
      chk("unf0", 64'(unf0), 64'(m_unf[0]));     chk("unf1", 64'(unf1), 64'(m_unf[1]));
      chk("hit0", 64'(hit0), 64'(m_hit[0]));     chk("hit1", 64'(hit1), 64'(m_hit[1]));
      chk("mis0", 64'(mis0), 64'(m_mis[0]));     chk("mis1", 64'(mis1), 64'(m_mis[1]));
   endtask

   // inputs are set by the caller; check fetch address, advance model, clock, check state
   task automatic cycle();
      logic [29:0] x0, x1;
      #1;
      x0 = model_xipc(0);
      x1 = model_xipc(1);
      chk("addr0", 64'(addr0), 64'(x0[IW-3:0]));
      chk("addr1", 64'(addr1), 64'(x1[IW-3:0]));
      if (grst) model_reset();
      else if (x_en) model_step();
      @(posedge gclk);
      #1;
      check_regs();
   endtask

   task automatic set_idle();
      grst = 0; x_en = 1; ras_clr = 0; rMXALT = 0; rOPC = 0; rRD = 0; rRA = 0;
      xRESULT = 0; rRESULT = 0; rDWBDI = 0; rREGA = 0;
   endtask

   task automatic settle();
      int n = 0;
      set_idle();
      while ((m_skip[0] || m_bra[0]) && n < 8) begin
         cycle();
         n++;
      end
      if (m_skip[0] || m_bra[0]) begin
         n_chk++;
         n_fail++;
         $display("FAIL settle: skip still pending after %0d idle cycles", n);
      end
   endtask

   task automatic op_brl();
      settle();
      rOPC = 6'o46;
      rRA  = 5'b10100;
      cycle();
      set_idle();
   endtask

   task automatic op_rtd(input int inst, input bit good, input bit clr);
      settle();
      rOPC    = 6'o55;
      ras_clr = clr;
      xRESULT = good ? {model_top(inst) + 30'd2, 2'b00} : 32'd0;
      cycle();
      set_idle();
   endtask

   task automatic do_reset();
      set_idle();
      grst = 1;
      cycle();
      set_idle();
   endtask

   initial begin
      logic [29:0] brl_pc;
      set_idle();
      grst = 1;
      repeat (2) @(posedge gclk);
      #1;
      model_reset();
      grst = 0;

      // reset state and sequential fetch
      chk("rst_pc", 64'(pc0), 64'd0);
      chk("rst_cnt", 64'(cnt0), 64'd0);
      for (int k = 0; k < 5; k++) begin
         chk("seq_addr", 64'(addr0), 64'(k + 1));
         cycle();
      end
      chk("seq_pc", 64'(pc0), 64'd3);
      chk("seq_skip", 64'(skip0), 64'd0);

      // BNE with delay slot: not taken, then taken
      rOPC = 6'o47; rRD = 5'b10001; rREGA = 32'd0;
      #1 chk("bcc_nt_addr", 64'(addr0), 64'd6);
      cycle();
      rREGA = 32'd5; xRESULT = 32'h100;
      #1 chk("bcc_tgt", 64'(addr0), 64'h40);
      cycle();
      chk("bcc_dly", 64'(skip0), 64'd0);
      set_idle();
      cycle();
      chk("bcc_skip", 64'(skip0), 64'd1);

      // link then matching return
      settle();
      brl_pc = m_pc[0];
      op_brl();
      chk("brl_cnt", 64'(cnt0), 64'd1);
      chk("brl_top", 64'(top0), 64'(brl_pc));
      op_rtd(0, 1, 0);
      chk("rtd_hit", 64'(hit0), 64'd1);
      chk("rtd_cnt", 64'(cnt0), 64'd0);

      // RAW=1 overflow and underflow
      do_reset();
      repeat (3) op_brl();
      chk("ovf_small", 64'(ovf1), 64'd1);
      chk("cnt_small", 64'(cnt1), 64'd2);
      op_rtd(1, 1, 0);
      op_rtd(1, 1, 0);
      op_rtd(1, 0, 0);
      chk("unf_small", 64'(unf1), 64'd1);
      chk("hit_small", 64'(hit1), 64'd2);
      chk("mis_small", 64'(mis1), 64'd1);

      // return squashed by a non-delayed branch
      op_brl();
      settle();
      rOPC = 6'o46; rRA = 5'b00000; xRESULT = 32'h400;
      cycle();
      rOPC = 6'o55; xRESULT = {model_top(0) + 30'd2, 2'b00};
      cycle();
      chk("sq_cnt", 64'(cnt0), 64'd1);

      // pipeline hold
      for (int k = 0; k < 4; k++) begin
         x_en = 0; rOPC = 6'o55; rRA = 5'($urandom); xRESULT = $urandom; ras_clr = 1;
         cycle();
      end
      set_idle();

      // CW=2 saturation and clear coinciding with a hit
      do_reset();
      repeat (4) begin
         op_brl();
         op_rtd(1, 1, 0);
      end
      chk("sat_hit", 64'(hit1), 64'd3);
      op_brl();
      op_rtd(1, 1, 1);
      chk("clr_hit", 64'(hit1), 64'd0);
      chk("clr_cnt", 64'(cnt1), 64'd0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         grst    = ($urandom_range(0, 99) < 2);
         x_en    = ($urandom_range(0, 9) != 0);
         ras_clr = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 6))
            0, 1:    rOPC = 6'o00;
            2:       rOPC = 6'o47;
            3:       rOPC = 6'o57;
            4:       rOPC = 6'o46;
            5:       rOPC = 6'o56;
            default: rOPC = 6'o55;
         endcase
         rRD     = 5'($urandom);
         rRA     = 5'($urandom);
         rMXALT  = 2'($urandom);
         rREGA   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         rRESULT = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         rDWBDI  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         xRESULT = $urandom;
         if (rOPC == 6'o55 && $urandom_range(0, 1) == 1)
            xRESULT = {model_top(c % 2) + 30'd2, 2'b00};
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
